sync_fifo_stream_reader: RTL and testbench

//  Read-side controller for sync_fifo: converts the FIFO's RD_EN/EMPTY/DATA_OUT
//  (1-cycle registered read latency) into a valid/ready stream with burst framing.

---
 rtl/sync_fifo_stream_reader.sv | 131 +++++++++++++
 tb/tb_sync_fifo_stream_reader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_stream_reader.sv
// rtl/sync_fifo_stream_reader.sv - read-side valid/ready adapter for sync_fifo with burst framing and flush
// Optional feature: define SYNC_FIFO_READER_PARITY_EN to add the M_PARITY output.
module sync_fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = $clog2(BURST_LEN) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FIFO_EMPTY,
  output logic             FIFO_RD_EN,
  input  logic [WIDTH-1:0] FIFO_DATA,
  output logic [WIDTH-1:0] M_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic             M_LAST,
  input  logic             FLUSH,
  output logic             BUSY
`ifdef SYNC_FIFO_READER_PARITY_EN
  ,
  output logic             M_PARITY
`endif
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam logic [CNT_WIDTH-1:0] BEAT_MAX = CNT_WIDTH'(BURST_LEN - 1);

  state_t               state;
  logic [WIDTH-1:0]     head_q;
  logic [WIDTH-1:0]     tail_q;
  logic [1:0]           occ;
  logic                 inflight;
  logic [CNT_WIDTH-1:0] beat;

  logic                 pop;
  logic [2:0]           credit;
  logic                 run_upd;
  logic                 head_load;
  logic                 tail_load;
  logic [WIDTH-1:0]     head_d;
  logic [1:0]           occ_d;

  assign pop     = M_VALID & M_READY;
  assign credit  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign run_upd = (state == ST_RUN) && !FLUSH;

  // Reads are held off during reset so the FIFO never loses a word that nobody will capture.
  always_comb begin
    FIFO_RD_EN = 1'b0;
    if (!RST && !FIFO_EMPTY)
      FIFO_RD_EN = (state == ST_FLUSH) || (credit < 3'd2);
  end

  assign M_VALID = (occ != 2'd0);
  assign M_DATA  = head_q;
  assign M_LAST  = M_VALID & (beat == BEAT_MAX);

  always_comb begin
    head_load = 1'b0;
    tail_load = 1'b0;
    head_d    = tail_q;
    occ_d     = occ;
    case ({pop, inflight})
      2'b11: begin
        head_load = 1'b1;
        if (occ == 2'd2) tail_load = 1'b1;
        else             head_d    = FIFO_DATA;
      end
      2'b10: begin
        occ_d = occ - 2'd1;
        if (occ == 2'd2) head_load = 1'b1;
      end
      2'b01: begin
        occ_d = occ + 2'd1;
        if (occ == 2'd0) begin
          head_load = 1'b1;
          head_d    = FIFO_DATA;
        end else begin
          tail_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_RUN;
      head_q   <= '0;
      tail_q   <= '0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      beat     <= '0;
      BUSY     <= 1'b0;
    end else begin
      inflight <= FIFO_RD_EN;
      case (state)
        ST_RUN: begin
          if (FLUSH) begin
            state <= ST_FLUSH;
            BUSY  <= 1'b1;
            occ   <= 2'd0;
            beat  <= '0;
          end else begin
            occ <= occ_d;
            if (head_load) head_q <= head_d;
            if (tail_load) tail_q <= FIFO_DATA;
            if (pop) beat <= (beat == BEAT_MAX) ? '0 : beat + 1'b1;
          end
        end
        ST_FLUSH: begin
          // Words returned while flushing are dropped; exit only once nothing is left in flight.
          if (FIFO_EMPTY && !inflight) begin
            state <= ST_RUN;
            BUSY  <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef SYNC_FIFO_READER_PARITY_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                        M_PARITY <= 1'b0;
    else if (run_upd && head_load)  M_PARITY <= ^head_d;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// tb/tb_sync_fifo_stream_reader.sv - randomized self-checking bench for sync_fifo_stream_reader
// Parity checks are compiled in when SYNC_FIFO_READER_PARITY_EN is defined.
module tb_sync_fifo_stream_reader;

  localparam int W  = 8;
  localparam int BL = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         FIFO_EMPTY;
  logic         FIFO_RD_EN;
  logic [W-1:0] FIFO_DATA;
  logic [W-1:0] M_DATA;
  logic         M_VALID;
  logic         M_READY;
  logic         M_LAST;
  logic         FLUSH;
  logic         BUSY;
`ifdef SYNC_FIFO_READER_PARITY_EN
  logic         M_PARITY;
`endif

  always #5 CLK = ~CLK;

  sync_fifo_stream_reader #(.WIDTH(W), .BURST_LEN(BL)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_RD_EN (FIFO_RD_EN),
    .FIFO_DATA  (FIFO_DATA),
    .M_DATA     (M_DATA),
    .M_VALID    (M_VALID),
    .M_READY    (M_READY),
    .M_LAST     (M_LAST),
    .FLUSH      (FLUSH),
    .BUSY       (BUSY)
`ifdef SYNC_FIFO_READER_PARITY_EN
    ,
    .M_PARITY   (M_PARITY)
`endif
  );

  int checks = 0;
  int passed = 0;

  // FIFO contents, pending writes, and the reference view of the stream side
  int fifo_q[$];
  int wr_q[$];
  int mbuf[$];
  bit m_infl;
  int m_infl_word;
  int m_beat;
  bit m_flush;

  bit p_rst = 1'b1, p_flush, p_pop, p_empty = 1'b1, dut_rd;
  int cyc = 0;

  int obs_d[$];
  bit obs_l[$];
  int obs_c[$];
  int rd_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void model_clear();
    mbuf.delete();
    m_infl  = 1'b0;
    m_beat  = 0;
    m_flush = 1'b0;
  endfunction

  function automatic void clear_obs();
    obs_d.delete();
    obs_l.delete();
    obs_c.delete();
    rd_c.delete();
  endfunction

  task automatic step(input bit rst, input bit ready, input bit flush);
    bit exp_valid;
    bit pop;
    bit rd;
    @(posedge CLK);
    #1;
    cyc++;
    if (p_rst) model_clear();
    else if (m_flush) begin
      if (p_empty && !m_infl) m_flush = 1'b0;
    end else if (p_flush) begin
      mbuf.delete();
      m_beat  = 0;
      m_flush = 1'b1;
    end else begin
      if (p_pop) begin
        void'(mbuf.pop_front());
        m_beat = (m_beat + 1) % BL;
      end
      if (m_infl) mbuf.push_back(m_infl_word);
    end
    m_infl = 1'b0;
    if (dut_rd && fifo_q.size() > 0) begin
      m_infl_word = fifo_q.pop_front();
      FIFO_DATA   = W'(m_infl_word);
      m_infl      = 1'b1;
    end
    while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
    FIFO_EMPTY = (fifo_q.size() == 0);
    RST     = rst;
    M_READY = ready;
    FLUSH   = flush;
    if (rst) model_clear();
    #1;
    exp_valid = (mbuf.size() > 0);
    pop       = exp_valid && ready;
    if (rst || fifo_q.size() == 0) rd = 1'b0;
    else if (m_flush)              rd = 1'b1;
    else                           rd = (mbuf.size() + int'(m_infl) - int'(pop)) < 2;
    chk("m_valid", M_VALID, exp_valid);
    if (exp_valid) chk("m_data", M_DATA, mbuf[0]);
    chk("m_last", M_LAST, exp_valid && (m_beat == BL - 1));
    chk("busy", BUSY, m_flush);
    chk("fifo_rd_en", FIFO_RD_EN, rd);
`ifdef SYNC_FIFO_READER_PARITY_EN
    if (exp_valid) chk("m_parity", M_PARITY, ^W'(mbuf[0]));
`endif
    if (M_VALID && ready) begin
      obs_d.push_back(M_DATA);
      obs_l.push_back(M_LAST);
      obs_c.push_back(cyc);
    end
    if (FIFO_RD_EN) rd_c.push_back(cyc);
    p_rst   = rst;
    p_flush = flush;
    p_pop   = pop;
    p_empty = FIFO_EMPTY;
    dut_rd  = FIFO_RD_EN;
  endtask

  initial begin
    RST        = 1'b1;
    M_READY    = 1'b0;
    FLUSH      = 1'b0;
    FIFO_EMPTY = 1'b1;
    FIFO_DATA  = '0;
    model_clear();
    #1;
    chk("reset_m_valid", M_VALID, 0);
    chk("reset_m_data", M_DATA, 0);
    chk("reset_m_last", M_LAST, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_rd_en", FIFO_RD_EN, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);

    // Throughput: eight preloaded words stream out back to back
    clear_obs();
    wr_q = {1, 2, 3, 4, 5, 6, 7, 8};
    for (int i = 0; i < 14; i++) step(0, 1, 0);
    chk("tput_count", obs_d.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("tput_data", (i < obs_d.size()) ? obs_d[i] : -1, i + 1);
      chk("tput_last", (i < obs_l.size()) ? obs_l[i] : 1'bx, (i == 3) || (i == 7));
    end
    chk("tput_latency", (obs_c.size() > 0 && rd_c.size() > 0) ? obs_c[0] - rd_c[0] : -1, 2);
    chk("tput_back_to_back", (obs_c.size() == 8) ? obs_c[7] - obs_c[0] : -1, 7);

    // Backpressure: stall five cycles after the first valid word
    clear_obs();
    wr_q = {1, 2, 3, 4, 5, 6, 7, 8};
    for (int i = 0; i < 10 && !M_VALID; i++) step(0, 0, 0);
    chk("bp_first_valid", M_VALID, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("bp_rd_stopped", FIFO_RD_EN, 0);
    chk("bp_hold_data", M_DATA, 8'h01);
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    chk("bp_count", obs_d.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("bp_order", (i < obs_d.size()) ? obs_d[i] : -1, i + 1);

    // Single word: exactly one read strobe
    clear_obs();
    wr_q = {8'h5A};
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    chk("empty_rd_pulses", rd_c.size(), 1);
    chk("empty_pop_count", obs_d.size(), 1);
    chk("empty_word", (obs_d.size() > 0) ? obs_d[0] : -1, 8'h5A);
    chk("empty_valid_low", M_VALID, 0);

    // Flush with beat parked on the final beat and a write landing mid-flush
    clear_obs();
    wr_q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    for (int i = 0; i < 12 && obs_d.size() < 3; i++) step(0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("flush_pre_valid", M_VALID, 1);
    step(0, 0, 1);
    wr_q = {8'h77};
    step(0, 1, 0);
    chk("flush_valid_drop", M_VALID, 0);
    chk("flush_busy", BUSY, 1);
    for (int i = 0; i < 30 && BUSY; i++) step(0, 1, 0);
    chk("flush_done", BUSY, 0);
    chk("flush_fifo_drained", fifo_q.size(), 0);
    chk("flush_no_pops", obs_d.size(), 3);
    wr_q = {8'hAA};
    for (int i = 0; i < 10 && obs_d.size() < 4; i++) step(0, 1, 0);
    chk("flush_next_word", (obs_d.size() > 3) ? obs_d[3] : -1, 8'hAA);
    chk("flush_next_not_last", (obs_l.size() > 3) ? obs_l[3] : 1'bx, 0);

    // Reset mid-stream with a full output buffer
    clear_obs();
    wr_q = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("rst_pre_valid", M_VALID, 1);
    chk("rst_pre_rd_stopped", FIFO_RD_EN, 0);
    step(1, 0, 0);
    chk("rst_mid_valid", M_VALID, 0);
    chk("rst_mid_last", M_LAST, 0);
    chk("rst_mid_busy", BUSY, 0);
    step(1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    chk("rst_after_count", obs_d.size(), 6);
    chk("rst_after_first", (obs_d.size() > 0) ? obs_d[0] : -1, 8'h23);
    chk("rst_after_last", (obs_l.size() > 3) ? obs_l[3] : 1'bx, 1);

    // Random traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) wr_q.push_back(int'($urandom_range(0, 255)));
      if ($urandom_range(0, 5) == 0) wr_q.push_back(int'($urandom_range(0, 255)));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
    end
    for (int i = 0; i < 40; i++) step(0, 1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
